// File: rtl/sync_fifo_pkg.sv
// Shared types for the single-clock FIFO: per-cycle operation encoding.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package sync_fifo_pkg;

  // Accepted operation in one cycle, encoded as {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Combine the accepted write/read strobes into one operation code.
  function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({wr_acc, rd_acc});
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write port, registered read port.
// Latency: write visible to a read one edge later; read data valid after the read edge.
// Backpressure: none; the caller only strobes accepted operations.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_vld_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i,
  input  logic                  rd_vld_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_dat_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_dat_q;

  // Storage is deliberately left unreset; only the output register clears.
  always_ff @(posedge clk) begin
    if (wr_vld_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Registered read port; holds its value until the next accepted read.
  // A same-edge write to the read address returns the old word, which is
  // what a full FIFO needs when reading and writing simultaneously.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else if (rd_vld_i) begin
      rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO of 2^ADDR_WIDTH words with full/empty flags.
// Latency: write readable one edge later; read data registered, valid after the read edge.
// Backpressure: writes on full (without a read) and reads on empty are silently dropped.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_acc;
  logic                  rd_acc;
  fifo_op_e              op;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // A read frees a slot in the same edge, so a full FIFO can also accept a write.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  assign op     = decode_op(wr_acc, rd_acc);

  // Next-state for pointers and occupancy from the accepted operation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case (op)
      OP_WR:   count_d = count_q + 1'b1;
      OP_RD:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_vld_i (wr_acc),
    .wr_addr_i(wr_ptr_q),
    .wr_dat_i (data_in),
    .rd_vld_i (rd_acc),
    .rd_addr_i(rd_ptr_q),
    .rd_dat_o (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo with a queue scoreboard of stored words.
// Latency: checks sample #1 after each rising edge.
// Backpressure: the scoreboard decides acceptance from its own occupancy.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];
  logic [7:0] exp_dout;
  bit         exp_full;
  bit         exp_empty;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .data_in (data_in),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle; the scoreboard pushes on accepted writes and pops on accepted reads.
  task automatic step(input bit wr, input bit rd, input logic [7:0] d);
    bit rd_ok;
    bit wr_ok;
    wr_en   = wr;
    rd_en   = rd;
    data_in = d;
    rd_ok = rd && (sb_q.size() != 0);
    wr_ok = wr && ((sb_q.size() < 16) || rd_ok);
    @(posedge clk);
    #1;
    if (rd_ok) exp_dout = sb_q.pop_front();
    if (wr_ok) sb_q.push_back(d);
    exp_full  = (sb_q.size() == 16);
    exp_empty = (sb_q.size() == 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    exp_dout  = 8'h00;
    exp_full  = 1'b0;
    exp_empty = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (data_out !== 8'h00 || empty !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: dout=%h empty=%b full=%b want dout=00 empty=1 full=0", data_out, empty, full);
    end
  endtask

  task automatic test_read_empty();
    step(1'b0, 1'b1, 8'h00);
    total++;
    if (data_out !== 8'h00 || empty !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL read_empty: dout=%h empty=%b full=%b want 00/1/0", data_out, empty, full);
    end
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h00);
    total++;
    if (data_out !== 8'h3C || empty !== 1'b1) begin
      bad++;
      $display("FAIL read_empty_no_ptr_move: dout=%h empty=%b want 3c/1", data_out, empty);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    total++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      bad++;
      $display("FAIL fill_flags: full=%b empty=%b want 1/0", full, empty);
    end
    step(1'b1, 1'b0, 8'hAA);
    total++;
    if (full !== 1'b1 || sb_q.size() != 16) begin
      bad++;
      $display("FAIL overflow_ignored: full=%b want 1", full);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      total++;
      if (data_out !== exp_dout || data_out !== 8'(i) || full !== exp_full || empty !== exp_empty) begin
        bad++;
        $display("FAIL fill_drain[%0d]: dout=%h full=%b empty=%b want %h/%b/%b", i, data_out, full, empty, 8'(i), exp_full, exp_empty);
      end
    end
    total++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: empty=%b full=%b want 1/0", empty, full);
    end
  endtask

  task automatic test_single();
    step(1'b1, 1'b0, 8'h11);
    total++;
    if (empty !== 1'b0) begin
      bad++;
      $display("FAIL single_not_empty: empty=%b want 0", empty);
    end
    step(1'b0, 1'b1, 8'h00);
    total++;
    if (data_out !== 8'h11 || empty !== 1'b1) begin
      bad++;
      $display("FAIL single_read: dout=%h empty=%b want 11/1", data_out, empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h80 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00);
      total++;
      if (data_out !== exp_dout) begin
        bad++;
        $display("FAIL wrap_pre[%0d]: dout=%h want %h", i, data_out, exp_dout);
      end
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h20 + 8'(i));
    total++;
    if (full !== 1'b1) begin
      bad++;
      $display("FAIL wrap_full: full=%b want 1", full);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      total++;
      if (data_out !== exp_dout || data_out !== 8'h20 + 8'(i)) begin
        bad++;
        $display("FAIL wrap_read[%0d]: dout=%h want %h", i, data_out, 8'h20 + 8'(i));
      end
    end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
    step(1'b1, 1'b1, 8'h55);
    total++;
    if (data_out !== 8'h60 || full !== 1'b1) begin
      bad++;
      $display("FAIL simul_full: dout=%h full=%b want 60/1", data_out, full);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      total++;
      if (data_out !== exp_dout || full !== exp_full || empty !== exp_empty) begin
        bad++;
        $display("FAIL simul_full_drain[%0d]: dout=%h full=%b empty=%b want %h/%b/%b", i, data_out, full, empty, exp_dout, exp_full, exp_empty);
      end
    end
    total++;
    if (data_out !== 8'h55 || empty !== 1'b1) begin
      bad++;
      $display("FAIL simul_full_last: dout=%h empty=%b want 55/1", data_out, empty);
    end
  endtask

  task automatic test_simul_empty();
    step(1'b1, 1'b1, 8'h77);
    total++;
    if (data_out !== 8'h55 || empty !== 1'b0) begin
      bad++;
      $display("FAIL simul_empty: dout=%h empty=%b want 55/0", data_out, empty);
    end
    step(1'b0, 1'b1, 8'h00);
    total++;
    if (data_out !== 8'h77 || empty !== 1'b1) begin
      bad++;
      $display("FAIL simul_empty_read: dout=%h empty=%b want 77/1", data_out, empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
    do_reset();
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid: empty=%b full=%b dout=%h want 1/0/00", empty, full, data_out);
    end
    step(1'b0, 1'b1, 8'h00);
    total++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_read: dout=%h empty=%b want 00/1", data_out, empty);
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    exp_dout  = 8'h00;
    exp_full  = 1'b0;
    exp_empty = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_read_empty();
    test_fill();
    test_single();
    test_wrap();
    test_simul_full();
    test_simul_empty();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
